// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a small write-buffer FIFO in front of a single-port array.
// Reads answer in one cycle, forwarding from the youngest matching buffered write.
module data_mem_responder #(
  parameter int N        = 32,
  parameter int DEPTH    = 64,
  parameter int WB_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mem_write_en,
  input  logic         mem_read_en,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] mem_data_write_in,
  output logic [N-1:0] memory_data_read_out,
  output logic         read_valid,
  output logic         stall,
  output logic         overflow_err,
  output logic         addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW    = $clog2(WB_DEPTH + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} wb_state_e;

  logic [N-1:0]     mem_q     [DEPTH];
  logic [N-1:0]     mem_d     [DEPTH];
  logic [IDX_W-1:0] wb_idx_q  [WB_DEPTH];
  logic [IDX_W-1:0] wb_idx_d  [WB_DEPTH];
  logic [N-1:0]     wb_data_q [WB_DEPTH];
  logic [N-1:0]     wb_data_d [WB_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  wb_state_e        state_q, state_d;
  logic             read_valid_q, read_valid_d;
  logic [N-1:0]     rdata_q, rdata_d;
  logic             overflow_q, overflow_d;
  logic             addr_err_q, addr_err_d;

  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             push;
  logic             pop;
  logic             fwd_hit;
  logic [N-1:0]     fwd_data;
  logic             unused_addr_bits;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= WB_DEPTH) s = s - WB_DEPTH;
    return PW'(s);
  endfunction

  assign idx              = addr[IDX_W+1:2];
  assign out_of_range     = |addr[N-1:IDX_W+2];
  assign unused_addr_bits = ^addr[1:0];

  assign stall = (count_q == CW'(WB_DEPTH));
  assign push  = mem_write_en & ~stall & ~out_of_range;
  assign pop   = ~mem_read_en & (state_q != ST_EMPTY);

  // Walk oldest to youngest so the last hit wins; uses pre-push contents only.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (i < int'(count_q) && wb_idx_q[wrap_add(rd_ptr_q, i)] == idx) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[wrap_add(rd_ptr_q, i)];
      end
    end
  end

  always_comb begin
    mem_d        = mem_q;
    wb_idx_d     = wb_idx_q;
    wb_data_d    = wb_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    read_valid_d = mem_read_en;
    rdata_d      = rdata_q;
    overflow_d   = overflow_q | (mem_write_en & stall);
    addr_err_d   = addr_err_q | ((mem_write_en | mem_read_en) & out_of_range);

    if (push) begin
      wb_idx_d[wr_ptr_q]  = idx;
      wb_data_d[wr_ptr_q] = mem_data_write_in;
      wr_ptr_d            = wrap_add(wr_ptr_q, 1);
    end

    if (pop) begin
      mem_d[wb_idx_q[rd_ptr_q]] = wb_data_q[rd_ptr_q];
      rd_ptr_d                  = wrap_add(rd_ptr_q, 1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == CW'(WB_DEPTH)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PARTIAL;
    end

    if (mem_read_en) begin
      if (out_of_range) begin
        rdata_d = '0;
      end else if (fwd_hit) begin
        rdata_d = fwd_data;
      end else begin
        rdata_d = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_idx_q[i]  <= '0;
        wb_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_EMPTY;
      read_valid_q <= 1'b0;
      rdata_q      <= '0;
      overflow_q   <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wb_idx_q     <= wb_idx_d;
      wb_data_q    <= wb_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      read_valid_q <= read_valid_d;
      rdata_q      <= rdata_d;
      overflow_q   <= overflow_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign memory_data_read_out = rdata_q;
  assign read_valid           = read_valid_q;
  assign overflow_err         = overflow_q;
  assign addr_err             = addr_err_q;

endmodule
